// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream word channel feeding the configurable UART transmitter.
// The source side uses the master modport, the transmitter the slave modport.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_cfg.sv
// AXI4-Stream UART transmitter: LSB-first, selectable parity and stop bits,
// one-entry holding register so consecutive frames leave no idle gap.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_cfg_if.slave       s_axis,
  output logic               txd,
  output logic               busy,
  input  logic [15:0]        prescale,
  input  logic [1:0]         parity_mode,
  input  logic               stop2
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state, state_nxt;
  logic [18:0]           timer, timer_nxt;
  logic [3:0]            bit_idx, bit_idx_nxt;
  logic                  stop_idx, stop_idx_nxt;
  logic                  txd_nxt, busy_nxt;
  logic                  hold_full, hold_full_nxt;
  logic                  tready_r;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [15:0]           pre_lat;
  logic                  par_en_lat;
  logic                  stop2_lat;
  logic                  par_bit;
  logic                  accept, launch, shift_en, bit_end;
  logic [18:0]           period_lat;

  // A prescale of zero behaves like one so the timer never starts at zero.
  function automatic logic [18:0] bit_period(input logic [15:0] pre);
    return {((pre == 16'd0) ? 16'd1 : pre), 3'b000};
  endfunction

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic [1:0] mode);
    return (^data) ^ (mode == 2'b10);
  endfunction

  assign accept        = s_axis.tvalid && tready_r;
  assign s_axis.tready = tready_r;
  assign bit_end       = (timer == 19'd1);
  assign period_lat    = bit_period(pre_lat);

  always_comb begin
    state_nxt     = state;
    timer_nxt     = (timer != 19'd0) ? (timer - 19'd1) : 19'd0;
    bit_idx_nxt   = bit_idx;
    stop_idx_nxt  = stop_idx;
    txd_nxt       = txd;
    busy_nxt      = busy;
    launch        = 1'b0;
    shift_en      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_full) launch = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          txd_nxt     = shift_reg[0];
          timer_nxt   = period_lat;
          bit_idx_nxt = 4'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_nxt = period_lat;
          if (bit_idx == 4'(DATA_WIDTH - 1)) begin
            stop_idx_nxt = 1'b0;
            if (par_en_lat) begin
              state_nxt = ST_PARITY;
              txd_nxt   = par_bit;
            end else begin
              state_nxt = ST_STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            shift_en    = 1'b1;
            txd_nxt     = shift_reg[1];
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt    = ST_STOP;
          txd_nxt      = 1'b1;
          timer_nxt    = period_lat;
          stop_idx_nxt = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_lat && !stop_idx) begin
            stop_idx_nxt = 1'b1;
            timer_nxt    = period_lat;
          end else if (hold_full) begin
            launch = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase

    // Launch overrides the per-state defaults: start bit on the next cycle.
    if (launch) begin
      state_nxt = ST_START;
      txd_nxt   = 1'b0;
      busy_nxt  = 1'b1;
      timer_nxt = bit_period(prescale);
    end

    hold_full_nxt = hold_full;
    if (launch)      hold_full_nxt = 1'b0;
    else if (accept) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= 19'd0;
      bit_idx    <= 4'd0;
      stop_idx   <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      hold_full  <= 1'b0;
      tready_r   <= 1'b0;
      pre_lat    <= 16'd0;
      par_en_lat <= 1'b0;
      stop2_lat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bit_idx   <= bit_idx_nxt;
      stop_idx  <= stop_idx_nxt;
      txd       <= txd_nxt;
      busy      <= busy_nxt;
      hold_full <= hold_full_nxt;
      tready_r  <= !hold_full_nxt;
      if (launch) begin
        pre_lat    <= prescale;
        par_en_lat <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        stop2_lat  <= stop2;
      end
    end
  end

  // Payload registers carry no reset; their contents only matter once launched.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= s_axis.tdata;
    if (launch) begin
      shift_reg <= hold_data;
      par_bit   <= calc_parity(hold_data, parity_mode);
    end else if (shift_en) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: words queued at handshake, line decoded
// cycle by cycle and compared with a frame model built from the queued word.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd1;
  logic [1:0]  parity_mode = 2'b00;
  logic [1:0]  pm7 = 2'b01;
  logic        stop2 = 1'b0;
  logic        txd, busy, txd7, busy7;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_active = 1'b0;
  logic just_ended = 1'b0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        stop2;
    logic [15:0] pre;
    logic        lat_chk;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  uart_tx_cfg_if #(.DATA_WIDTH(8)) s_axis8 ();
  uart_tx_cfg_if #(.DATA_WIDTH(7)) s_axis7 ();

  uart_tx_cfg #(.DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .s_axis(s_axis8), .txd(txd), .busy(busy),
    .prescale(prescale), .parity_mode(parity_mode), .stop2(stop2)
  );

  uart_tx_cfg #(.DATA_WIDTH(7)) u_dut7 (
    .clk(clk), .rst(rst), .s_axis(s_axis7), .txd(txd7), .busy(busy7),
    .prescale(prescale), .parity_mode(pm7), .stop2(stop2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    exp_t it;
    int   n;
    @(negedge clk);
    s_axis8.tdata  = d;
    s_axis8.tvalid = 1'b1;
    n = 0;
    while (s_axis8.tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("send_timeout", 32'(n), 32'd0);
      s_axis8.tvalid = 1'b0;
      return;
    end
    it.data    = d;
    it.pmode   = parity_mode;
    it.stop2   = stop2;
    it.pre     = prescale;
    it.lat_chk = (busy === 1'b0) && !mon_active && (sb_q.size() == 0);
    it.acc_cyc = cyc + 1;
    @(posedge clk);
    sb_q.push_back(it);
    #1 s_axis8.tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || mon_active || sb_q.size() != 0) && n < 5000);
    chk("idle_timeout", (n < 5000) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input exp_t it);
    logic [13:0] bits;
    int nb, per, bad_t, bad_b;
    logic mid;
    bits = '0;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = it.data[i];
    if (it.pmode == 2'b01) bits[nb++] = ^it.data;
    if (it.pmode == 2'b10) bits[nb++] = ~^it.data;
    bits[nb++] = 1'b1;
    if (it.stop2) bits[nb++] = 1'b1;
    per = ((it.pre == 16'd0) ? 1 : int'(it.pre)) * 8;
    mon_active = 1'b1;
    if (it.lat_chk) chk("launch_lat", 32'(cyc - it.acc_cyc), 32'd1);
    bad_t = 0;
    bad_b = 0;
    mid = 1'bx;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < per; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst) begin
          mon_active = 1'b0;
          return;
        end
        if (txd !== bits[b]) bad_t++;
        if (busy !== 1'b1) bad_b++;
        if (c == per / 2) mid = txd;
      end
      chk($sformatf("frame%02h_bit%0d", it.data, b), 32'(mid), 32'(bits[b]));
    end
    chk("txd_every_cycle", 32'(bad_t), 32'd0);
    chk("busy_whole_frame", 32'(bad_b), 32'd0);
    mon_active = 1'b0;
    just_ended = 1'b1;
  endtask

  initial begin : monitor
    exp_t it;
    forever begin
      @(negedge clk);
      if (rst) begin
        just_ended = 1'b0;
      end else begin
        if (just_ended) begin
          just_ended = 1'b0;
          if (sb_q.size() > 0) begin
            chk("b2b_start", 32'(txd), 32'd0);
            chk("b2b_busy", 32'(busy), 32'd1);
          end else begin
            chk("busy_drop", 32'(busy), 32'd0);
            chk("idle_txd", 32'(txd), 32'd1);
          end
        end
        if (txd === 1'b0) begin
          if (sb_q.size() == 0) begin
            chk("unexp_start", 32'(txd), 32'd1);
          end else begin
            it = sb_q.pop_front();
            check_frame(it);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [9:0] e7;
    s_axis8.tdata  = '0;
    s_axis8.tvalid = 1'b0;
    s_axis7.tdata  = '0;
    s_axis7.tvalid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tready", 32'(s_axis8.tready), 32'd0);
    rst = 1'b0;
    chk("tready_before_edge", 32'(s_axis8.tready), 32'd0);
    @(negedge clk);
    chk("tready_after_edge", 32'(s_axis8.tready), 32'd1);

    // 8N1, prescale 1
    send(8'hA5);
    wait_idle();

    // 8E1 and 8O1
    parity_mode = 2'b01;
    send(8'h07);
    wait_idle();
    parity_mode = 2'b10;
    send(8'h07);
    wait_idle();
    parity_mode = 2'b11;
    send(8'h3B);
    wait_idle();

    // 8N2 back-to-back
    parity_mode = 2'b00;
    stop2 = 1'b1;
    send(8'h81);
    send(8'h7E);
    repeat (40) @(negedge clk);
    chk("tready_hold_full", 32'(s_axis8.tready), 32'd0);
    repeat (88) @(negedge clk);
    chk("tready_after_launch", 32'(s_axis8.tready), 32'd1);
    wait_idle();

    // prescale 0, then mid-frame prescale change
    stop2 = 1'b0;
    prescale = 16'd0;
    send(8'h5A);
    wait_idle();
    prescale = 16'd1;
    send(8'hC3);
    repeat (30) @(negedge clk);
    prescale = 16'd4;
    wait_idle();
    send(8'h96);
    wait_idle();

    // DATA_WIDTH=7, 7E1, 0x41: 0,1,0,0,0,0,0,1,(parity 0),1
    prescale = 16'd1;
    e7 = 10'b1010000010;
    @(negedge clk);
    s_axis7.tdata  = 7'h41;
    s_axis7.tvalid = 1'b1;
    n = 0;
    while (s_axis7.tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 s_axis7.tvalid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd7 !== 1'b0 && n < 20);
    chk("w7_start_lat", 32'(n), 32'd2);
    for (int t = 0; t <= 80; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 80 && (t % 8) == 4) chk($sformatf("w7_bit%0d", t / 8), 32'(txd7), 32'(e7[t / 8]));
      if (t == 79) chk("w7_busy_end", 32'(busy7), 32'd1);
      if (t == 80) begin
        chk("w7_busy_drop", 32'(busy7), 32'd0);
        chk("w7_idle_txd", 32'(txd7), 32'd1);
      end
    end

    // reset during data bit 3
    parity_mode = 2'b00;
    send(8'hF0);
    repeat (36) @(posedge clk);
    #2;
    chk("pre_rst_txd", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tready", 32'(s_axis8.tready), 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rel_tready", 32'(s_axis8.tready), 32'd0);
    @(negedge clk);
    chk("rel_tready_edge", 32'(s_axis8.tready), 32'd1);
    send(8'h3C);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
